// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath.
// The master drives the datapath strobes; the slave supplies the decoded IR fields and memory handshake.
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             pc_write_cond_ne;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, halted, retired
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal, halted, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore FSM over a shared ALU and unified memory port,
// with memory-wait timeout, illegal-opcode halt and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_JR        = 4'd11,
    S_JAL       = 4'd12,
    S_HALT      = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               mem_wait;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, wait/retire bookkeeping and Moore control outputs.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    mem_wait  = 1'b0;
    retire    = 1'b0;

    bus.pc_write         = 1'b0;
    bus.pc_write_cond    = 1'b0;
    bus.pc_write_cond_ne = 1'b0;
    bus.iord             = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write        = 1'b0;
    bus.ir_write         = 1'b0;
    bus.reg_write        = 1'b0;
    bus.reg_dst          = 2'b00;
    bus.mem_to_reg       = 2'b00;
    bus.alu_src_a        = 1'b0;
    bus.alu_src_b        = 2'b00;
    bus.alu_op           = 2'b00;
    bus.pc_source        = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        mem_wait      = !bus.mem_ready;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target computed into ALUOut while decoding.
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE:        state_d = (bus.funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = S_JAL;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        mem_wait     = !bus.mem_ready;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        mem_wait      = !bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_ALU_WB;
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = (bus.opcode == OP_ORI) ? 2'b11 : 2'b00;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (bus.opcode == OP_RTYPE) ? 2'b01 : 2'b00;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a        = 1'b1;
        bus.alu_op           = 2'b01;
        bus.pc_source        = 2'b01;
        bus.pc_write_cond    = (bus.opcode == OP_BEQ);
        bus.pc_write_cond_ne = (bus.opcode == OP_BNE);
        state_d              = S_FETCH;
        retire               = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_write  = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_JAL: begin
        bus.pc_source  = 2'b10;
        bus.pc_write   = 1'b1;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        state_d        = S_FETCH;
        retire         = 1'b1;
      end
      S_JR: begin
        bus.pc_source = 2'b11;
        bus.pc_write  = 1'b1;
        state_d       = S_FETCH;
        retire        = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Memory that never answers is a bus error, not an illegal instruction.
    if (mem_wait && (wait_q == WAIT_LAST)) begin
      state_d = S_HALT;
    end

    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
    end

    // Reset kills every strobe even though the state register already reads FETCH.
    if (!rst_n) begin
      bus.pc_write         = 1'b0;
      bus.pc_write_cond    = 1'b0;
      bus.pc_write_cond_ne = 1'b0;
      bus.iord             = 1'b0;
      bus.mem_read         = 1'b0;
      bus.mem_write        = 1'b0;
      bus.ir_write         = 1'b0;
      bus.reg_write        = 1'b0;
      bus.reg_dst          = 2'b00;
      bus.mem_to_reg       = 2'b00;
      bus.alu_src_a        = 1'b0;
      bus.alu_src_b        = 2'b00;
      bus.alu_op           = 2'b00;
      bus.pc_source        = 2'b00;
    end
  end

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the MIPS datapath: decodes the instruction-register opcode/funct and steps the shared ALU, unified memory port, register file and PC through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one instruction at a time. It replaces the single-cycle control unit and ALU-op decode when the datapath runs with a single memory and one ALU. It stretches memory states on a ready handshake, halts on illegal opcodes or memory timeout, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 16: max consecutive wait cycles in a memory state before bus-error halt (≥1).
- CNT_W, 32: width of retired-instruction counter.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_write_cond_ne  out  1  PC load if ALU not zero (bne).
- iord  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready.
- ir_write  out  1  load IR.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 A.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 decode funct, 11 or.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],00}, 11 A (jr).
- state  out  4  current state encoding.
- illegal  out  1  sticky: halted on unknown opcode.
- halted  out  1  in HALT.
- retired  out  CNT_W  instructions completed, wraps.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, JR 11, JAL 12, HALT 15. Unlisted/default outputs are 0.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00. When mem_ready=1: ir_write=1, pc_write=1 (same cycle), next DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next: lw 100011/sw 101011 → MEM_ADDR; 000000 with funct 001000 → JR, other funct → R_EXEC; addi 001000/ori 001101 → I_EXEC; beq 000100/bne 000101 → BRANCH; j 000010 → JUMP; jal 000011 → JAL; anything else → HALT, set illegal.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: iord=1, mem_read=1; mem_ready → MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 → FETCH.
- MEM_WRITE: iord=1, mem_write=1; mem_ready → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALU_WB. I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) or 11 (ori) → ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 if opcode 000000 else 00 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write_cond=1 (beq) or pc_write_cond_ne=1 (bne) → FETCH.
- JUMP: pc_source=10, pc_write=1. JAL: same plus reg_write=1, reg_dst=10, mem_to_reg=10 (PC already PC+4). JR: pc_source=11, pc_write=1. All → FETCH.
- HALT: all strobes 0; remains until reset.
- Wait counter: increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0; clears on any state change. When it equals MEM_TIMEOUT-1 and mem_ready=0, next state HALT (illegal stays 0).
- retired: +1 on each transition from MEM_WB, MEM_WRITE, ALU_WB, BRANCH, JUMP, JAL, JR into FETCH; wraps mod 2^CNT_W.

## Timing
- Reset low: state=FETCH, wait counter=0, retired=0, illegal=0, halted=0, and every control output forced 0 regardless of state. First FETCH strobes appear the cycle after reset rises.
- Outputs are combinational from state (Moore) except FETCH ir_write/pc_write, which are gated by mem_ready in the same cycle.
- Cycle counts with zero wait: R/addi/ori 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3. Each mem_ready=0 cycle adds one.
- Reset asserted mid-instruction aborts it; no strobe survives, retired is not incremented.

## Test plan
- Reset low 3 cycles then high, mem_ready=1 → all outputs 0 during reset; cycle 1 after release state=0, mem_read=1, ir_write=1, pc_write=1.
- addi (001000), mem_ready=1 → states 0,1,10,7,0; ALU_WB shows reg_write=1, reg_dst=00; retired 0→1 after 4 cycles.
- lw with mem_ready low 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0; reg_dst=00, mem_to_reg=01 in MEM_WB; 7 cycles total.
- beq then bne then jal then jr (funct 001000) → pc_write_cond only for beq, pc_write_cond_ne only for bne; JAL reg_dst=10, mem_to_reg=10; JR pc_source=11; retired +4.
- opcode 111111 → DECODE→HALT, illegal=1, halted=1, all strobes 0 for 20 further cycles; reset clears.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT entered after 4 FETCH cycles, illegal=0, halted=1; second run asserting reset in MEM_READ → state=0 immediately, retired unchanged.
